// File: rtl/pipe_mult_pkg.sv
// Shared limits and helpers for the pipelined carry-save multiplier.
// Signed Baugh-Wooley support is built only when PIPE_MULT_SIGNED_EN is defined.
package pipe_mult_pkg;

    localparam int WIDTH_MIN  = 4;
    localparam int WIDTH_MAX  = 32;
    localparam int STAGES_MIN = 1;

    function automatic int rows_per_stage(input int width, input int stages);
        return width / stages;
    endfunction

    // Correction word: ones at column WIDTH and column 2*WIDTH-1.
    function automatic logic [2*WIDTH_MAX-1:0] bw_const(input int width);
        logic [2*WIDTH_MAX-1:0] c;
        c = '0;
        c[width]       = 1'b1;
        c[2*width-1]   = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_mult_if.sv
// Operand/result bundle between the operand registers and the result bus.
interface pipe_mult_if #(
    parameter int WIDTH = 32
);
    // ena=0 freezes the pipe and in_valid is ignored on that edge; in_valid=1 on an
    // enabled edge launches a, b, tc; out_valid qualifies product for one enabled cycle.
    logic               ena;
    logic               in_valid;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               tc;
    logic               out_valid;
    logic [2*WIDTH-1:0] product;

    modport master (
        output ena, in_valid, a, b, tc,
        input  out_valid, product
    );

    modport slave (
        input  ena, in_valid, a, b, tc,
        output out_valid, product
    );
endinterface

// File: rtl/pipe_mult_stage.sv
// One pipeline stage: ROWS carry-save partial-product rows starting at ROW_BASE, then a register.
// The final stage (LAST=1) is purely combinational; the top owns its product register.
module pipe_mult_stage #(
    parameter int WIDTH    = 32,
    parameter int ROWS     = 8,
    parameter int ROW_BASE = 0,
    parameter bit LAST     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               i_valid,
    input  logic               i_tc,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [2*WIDTH-1:0] i_sum,
    input  logic [2*WIDTH-1:0] i_carry,
    output logic               o_valid,
    output logic               o_tc,
    output logic [WIDTH-1:0]   o_a,
    output logic [WIDTH-1:0]   o_b,
    output logic [2*WIDTH-1:0] o_sum,
    output logic [2*WIDTH-1:0] o_carry
);

    logic [2*WIDTH-1:0] w_sum;
    logic [2*WIDTH-1:0] w_carry;
    logic [2*WIDTH-1:0] w_pp;
    logic [2*WIDTH-1:0] w_maj;
    logic [WIDTH-1:0]   w_row;

    // i_b arrives pre-shifted so bit r is global multiplier bit ROW_BASE+r.
    always_comb begin
        w_sum   = i_sum;
        w_carry = i_carry;
        w_pp    = '0;
        w_maj   = '0;
        w_row   = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_row = i_a & {WIDTH{i_b[r]}};
`ifdef PIPE_MULT_SIGNED_EN
            if (i_tc) begin
                if (ROW_BASE + r == WIDTH - 1)
                    w_row[WIDTH-2:0] = ~w_row[WIDTH-2:0];
                else
                    w_row[WIDTH-1] = ~w_row[WIDTH-1];
            end
`endif
            w_pp    = {{WIDTH{1'b0}}, w_row} << (ROW_BASE + r);
            w_maj   = (w_sum & w_carry) | (w_sum & w_pp) | (w_carry & w_pp);
            w_sum   = w_sum ^ w_carry ^ w_pp;
            w_carry = w_maj << 1;
        end
    end

`ifndef PIPE_MULT_SIGNED_EN
    logic w_unused_tc;
    assign w_unused_tc = i_tc;
`endif

    if (LAST) begin : g_comb
        logic w_unused_ctl;
        assign w_unused_ctl = clk ^ rst ^ ena;
        assign o_valid = i_valid;
        assign o_a     = i_a;
        assign o_b     = i_b;
        assign o_sum   = w_sum;
        assign o_carry = w_carry;
`ifdef PIPE_MULT_SIGNED_EN
        assign o_tc    = i_tc;
`else
        assign o_tc    = 1'b0;
`endif
    end else begin : g_reg
        logic               r_valid;
        logic [WIDTH-1:0]   r_a;
        logic [WIDTH-1:0]   r_b;
        logic [2*WIDTH-1:0] r_sum;
        logic [2*WIDTH-1:0] r_carry;

        always_ff @(posedge clk) begin
            if (rst)
                r_valid <= 1'b0;
            else if (ena)
                r_valid <= i_valid;
        end

        // Data loads bubbles too; only r_valid qualifies it.
        always_ff @(posedge clk) begin
            if (ena) begin
                r_a     <= i_a;
                r_b     <= i_b >> ROWS;
                r_sum   <= w_sum;
                r_carry <= w_carry;
            end
        end

`ifdef PIPE_MULT_SIGNED_EN
        logic r_tc;
        always_ff @(posedge clk) begin
            if (ena)
                r_tc <= i_tc;
        end
        assign o_tc = r_tc;
`else
        assign o_tc = 1'b0;
`endif

        assign o_valid = r_valid;
        assign o_a     = r_a;
        assign o_b     = r_b;
        assign o_sum   = r_sum;
        assign o_carry = r_carry;
    end

endmodule

// File: rtl/pipe_mult.sv
// Pipelined WIDTH x WIDTH -> 2*WIDTH carry-save array multiplier with a travelling valid tag.
// Define PIPE_MULT_SIGNED_EN to make tc select two's-complement (Baugh-Wooley) operation.
module pipe_mult
    import pipe_mult_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic      clk,
    input  logic      rst,
    pipe_mult_if.slave bus
);

    localparam int R = rows_per_stage(WIDTH, STAGES);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || STAGES < STAGES_MIN ||
        STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_mult: illegal WIDTH/STAGES combination");
    end

    logic               w_valid [STAGES+1];
    logic               w_tc    [STAGES+1];
    logic [WIDTH-1:0]   w_a     [STAGES+1];
    logic [WIDTH-1:0]   w_b     [STAGES+1];
    logic [2*WIDTH-1:0] w_sum   [STAGES+1];
    logic [2*WIDTH-1:0] w_carry [STAGES+1];
    logic [2*WIDTH-1:0] w_cpa;
    logic               w_unused;

    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_product;

    assign w_valid[0] = bus.in_valid;
    assign w_tc[0]    = bus.tc;
    assign w_a[0]     = bus.a;
    assign w_b[0]     = bus.b;
    assign w_sum[0]   = '0;

`ifdef PIPE_MULT_SIGNED_EN
    localparam logic [2*WIDTH_MAX-1:0] BW_FULL = bw_const(WIDTH);
    localparam logic [2*WIDTH-1:0]     BW      = BW_FULL[2*WIDTH-1:0];
    // Seeding the carry vector injects the Baugh-Wooley constants for free.
    assign w_carry[0] = bus.tc ? BW : '0;
`else
    assign w_carry[0] = '0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_mult_stage #(
            .WIDTH    (WIDTH),
            .ROWS     (R),
            .ROW_BASE (k * R),
            .LAST     (k == STAGES - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .ena     (bus.ena),
            .i_valid (w_valid[k]),
            .i_tc    (w_tc[k]),
            .i_a     (w_a[k]),
            .i_b     (w_b[k]),
            .i_sum   (w_sum[k]),
            .i_carry (w_carry[k]),
            .o_valid (w_valid[k+1]),
            .o_tc    (w_tc[k+1]),
            .o_a     (w_a[k+1]),
            .o_b     (w_b[k+1]),
            .o_sum   (w_sum[k+1]),
            .o_carry (w_carry[k+1])
        );
    end

    assign w_unused = ^{w_tc[STAGES], w_a[STAGES], w_b[STAGES]};
    assign w_cpa    = w_sum[STAGES] + w_carry[STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else if (bus.ena) begin
            r_out_valid <= w_valid[STAGES];
            if (w_valid[STAGES])
                r_product <= w_cpa;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;

endmodule

// File: tb/tb_pipe_mult.sv
// Scoreboard bench for pipe_mult: a 4-bit/2-stage and a 32-bit/4-stage instance side by side.
// Expected products come from an integer reference model honouring PIPE_MULT_SIGNED_EN.
module tb_pipe_mult;

    logic clk;
    logic rst;

    pipe_mult_if #(.WIDTH(4))  if4 ();
    pipe_mult_if #(.WIDTH(32)) if32 ();

    pipe_mult #(.WIDTH(4),  .STAGES(2)) dut4  (.clk(clk), .rst(rst), .bus(if4));
    pipe_mult #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp4_q[$];
    logic [63:0] exp32_q[$];
    int          due4_q[$];
    int          due32_q[$];

    int          en_cnt4  = 0;
    int          en_cnt32 = 0;
    logic        rst_q    = 1'b0;
    logic        en4_q    = 1'b0;
    logic        en32_q   = 1'b0;
    logic        exp_ov4;
    logic        exp_ov32;
    logic        last_ov4    = 1'b0;
    logic        last_ov32   = 1'b0;
    logic [63:0] last_prod4  = '0;
    logic [63:0] last_prod32 = '0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking / model ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic tc, input int w);
        logic [63:0] sa, sb, mask;
        logic        use_signed;
`ifdef PIPE_MULT_SIGNED_EN
        use_signed = tc;
`else
        use_signed = tc & 1'b0;
`endif
        sa = {32'd0, a};
        sb = {32'd0, b};
        if (use_signed) begin
            if (a[w-1]) sa = sa | (~64'd0 << w);
            if (b[w-1]) sb = sb | (~64'd0 << w);
        end
        mask = (w == 32) ? ~64'd0 : ((64'd1 << (2*w)) - 64'd1);
        return (sa * sb) & mask;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input logic en, input logic v, input logic [3:0] a,
                        input logic [3:0] b, input logic tc);
        if4.ena = en; if4.in_valid = v; if4.a = a; if4.b = b; if4.tc = tc;
    endtask

    task automatic set32(input logic en, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic tc);
        if32.ena = en; if32.in_valid = v; if32.a = a; if32.b = b; if32.tc = tc;
    endtask

    // ---------------- scoreboard push at accepting edges ----------------
    always @(posedge clk) begin
        rst_q  <= rst;
        en4_q  <= if4.ena;
        en32_q <= if32.ena;
        if (rst) begin
            exp4_q.delete();  due4_q.delete();
            exp32_q.delete(); due32_q.delete();
        end else begin
            if (if4.ena) begin
                en_cnt4 <= en_cnt4 + 1;
                if (if4.in_valid) begin
                    exp4_q.push_back(model(32'(if4.a), 32'(if4.b), if4.tc, 4));
                    due4_q.push_back(en_cnt4 + 2);
                end
            end
            if (if32.ena) begin
                en_cnt32 <= en_cnt32 + 1;
                if (if32.in_valid) begin
                    exp32_q.push_back(model(if32.a, if32.b, if32.tc, 32));
                    due32_q.push_back(en_cnt32 + 4);
                end
            end
        end
    end

    // ---------------- scoreboard compare, sampled on falling edge ----------------
    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_ov4",   64'(if4.out_valid), 64'd0);
            chk("rst_prod4", 64'(if4.product),   64'd0);
            last_ov4 = 1'b0; last_prod4 = '0;
        end else if (en4_q) begin
            exp_ov4 = (due4_q.size() > 0) && (due4_q[0] == en_cnt4);
            chk("ov4", 64'(if4.out_valid), 64'(exp_ov4));
            if (exp_ov4) begin
                last_prod4 = exp4_q.pop_front();
                void'(due4_q.pop_front());
            end
            chk("prod4", 64'(if4.product), last_prod4);
            last_ov4 = exp_ov4;
        end else begin
            chk("hold_ov4",   64'(if4.out_valid), 64'(last_ov4));
            chk("hold_prod4", 64'(if4.product),   last_prod4);
        end
    end

    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_ov32",   64'(if32.out_valid), 64'd0);
            chk("rst_prod32", if32.product,        64'd0);
            last_ov32 = 1'b0; last_prod32 = '0;
        end else if (en32_q) begin
            exp_ov32 = (due32_q.size() > 0) && (due32_q[0] == en_cnt32);
            chk("ov32", 64'(if32.out_valid), 64'(exp_ov32));
            if (exp_ov32) begin
                last_prod32 = exp32_q.pop_front();
                void'(due32_q.pop_front());
            end
            chk("prod32", if32.product, last_prod32);
            last_ov32 = exp_ov32;
        end else begin
            chk("hold_ov32",   64'(if32.out_valid), 64'(last_ov32));
            chk("hold_prod32", if32.product,        last_prod32);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] edge_a [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] edge_b [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        rst = 1'b1;
        set4(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        set32(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) step();
        rst = 1'b0;

        // Single unsigned pulse, then idle so out_valid must fall.
        set4(1'b1, 1'b1, 4'd15, 4'd15, 1'b0); step();
        set4(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);   repeat (3) step();

        // Signed corners and tc ignored/used depending on build, back to back.
        set4(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b1); step();
        set4(1'b1, 1'b1, 4'b1000, 4'b0111, 1'b1); step();
        set4(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1); step();
        set4(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1); step();
        set4(1'b1, 1'b1, 4'd7,    4'd9,    1'b0); step();
        set4(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);   repeat (3) step();

        // Stall: 3 ops, 5 frozen cycles with in_valid asserted (must be dropped), release.
        set4(1'b1, 1'b1, 4'd3,  4'd5,  1'b0); step();
        set4(1'b1, 1'b1, 4'd12, 4'd11, 1'b1); step();
        set4(1'b1, 1'b1, 4'd9,  4'd14, 1'b0); step();
        set4(1'b0, 1'b1, 4'd1,  4'd1,  1'b0); repeat (5) step();
        set4(1'b1, 1'b0, 4'd0,  4'd0,  1'b0); repeat (4) step();

        // 1000 back-to-back ops with mixed tc on the wide pipe.
        for (int i = 0; i < 1000; i++) begin
            if (i < 4)
                set32(1'b1, 1'b1, edge_a[i], edge_b[i], 1'(i % 2));
            else
                set32(1'b1, 1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            step();
        end
        set32(1'b1, 1'b0, 32'd0, 32'd0, 1'b0); repeat (6) step();

        // Random enable and valid on both pipes.
        for (int i = 0; i < 300; i++) begin
            set4(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 4'($urandom()), 4'($urandom()), 1'($urandom_range(0, 1)));
            set32(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            step();
        end
        set4(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        set32(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (6) step();

        // Reset mid-flight; the reset edge also carries in_valid and, for the wide pipe, ena=0.
        set32(1'b1, 1'b1, 32'd1234, 32'd5678, 1'b0); step();
        set32(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        set4(1'b1, 1'b1, 4'd3, 4'd5, 1'b0); step();
        rst = 1'b1;
        set32(1'b0, 1'b1, 32'd99, 32'd99, 1'b0);
        set4(1'b1, 1'b1, 4'd2, 4'd3, 1'b0); step();
        rst = 1'b0;
        set4(1'b1, 1'b1, 4'd7, 4'd9, 1'b0);
        set32(1'b1, 1'b1, 32'd7, 32'd9, 1'b0); step();
        set4(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        set32(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (10) step();

        chk("drain4",  64'(exp4_q.size()),  64'd0);
        chk("drain32", 64'(exp32_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
